// File: rtl/data_memory_pkg.sv
// Shared types, transfer-size constants and the access legality rule for data_memory.
package data_memory_pkg;

    localparam int unsigned MEM_BYTES_DEFAULT = 1024;

    typedef logic [3:0] xfer_size_t;

    localparam xfer_size_t XFER_B = 4'd1;
    localparam xfer_size_t XFER_H = 4'd2;
    localparam xfer_size_t XFER_W = 4'd4;
    localparam xfer_size_t XFER_D = 4'd8;

    // Size must be 1/2/4/8, naturally aligned, and the last byte inside the array.
    // The subtraction form avoids any overflow when address is near 2^64.
    function automatic logic is_legal(input logic [63:0] addr, input xfer_size_t size,
                                      input int unsigned mem_bytes);
        logic size_ok;
        logic aligned;
        logic in_range;
        size_ok  = size inside {XFER_B, XFER_H, XFER_W, XFER_D};
        aligned  = (addr & {60'd0, size - 4'd1}) == 64'd0;
        in_range = addr <= (64'(mem_bytes) - {60'd0, size});
        return size_ok && aligned && in_range;
    endfunction

endpackage

// File: rtl/data_memory_lane_steer.sv
// Big-endian lane map: memory byte i of an N-byte transfer sits on bus lane N-1-i.
module data_memory_lane_steer
    import data_memory_pkg::*;
(
    input  xfer_size_t       size,
    output logic [7:0][2:0]  lane,
    output logic [7:0]       used
);

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            used[i] = 4'(i) < size;
            lane[i] = 3'(size - 4'(i) - 4'd1);
        end
    end

endmodule

// File: rtl/data_memory.sv
// Byte-addressed big-endian data memory: combinational reads, posedge writes, async clear.
// Optional DATAMEM_ERR_EN adds an err output flagging illegal accesses.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] address,
    input  logic        write_enable,
    input  logic        read_enable,
    input  logic [63:0] write_data,
    input  logic [3:0]  xfer_size,
    output logic [63:0] read_data
`ifdef DATAMEM_ERR_EN
    ,
    output logic        err
`endif
);

    localparam int IDX_W = $clog2(MEM_BYTES);

    logic [7:0]       mem [MEM_BYTES];
    logic [IDX_W-1:0] idx;
    logic             legal;
    logic [7:0][2:0]  lane;
    logic [7:0]       used;

    assign idx   = address[IDX_W-1:0];
    assign legal = is_legal(address, xfer_size, MEM_BYTES);

    data_memory_lane_steer u_steer (
        .size (xfer_size),
        .lane (lane),
        .used (used)
    );

    // Byte indices wrap within IDX_W bits, but only in-range lanes are ever enabled.
    always_comb begin
        read_data = '0;
        if (read_enable && legal) begin
            for (int i = 0; i < 8; i++) begin
                if (used[i]) begin
                    read_data[{lane[i], 3'b000} +: 8] = mem[idx + IDX_W'(i)];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem[i] <= '0;
            end
        end else if (write_enable && legal) begin
            for (int i = 0; i < 8; i++) begin
                if (used[i]) begin
                    mem[idx + IDX_W'(i)] <= write_data[{lane[i], 3'b000} +: 8];
                end
            end
        end
    end

`ifdef DATAMEM_ERR_EN
    assign err = (read_enable || write_enable) && !legal;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (err && write_enable) begin
            $error("data_memory: illegal store addr=%h size=%0d", address, xfer_size);
        end
    end
`endif
`endif

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory with a byte-array reference model and per-cycle compare.
module tb_data_memory;

    localparam int MB = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] address = '0;
    logic        write_enable = 1'b0;
    logic        read_enable = 1'b0;
    logic [63:0] write_data = '0;
    logic [3:0]  xfer_size = 4'd8;
    logic [63:0] read_data;

    int checks = 0;
    int errors = 0;
    bit compare_on = 1'b0;

    logic [7:0] model_mem [MB];

    data_memory #(.MEM_BYTES(MB)) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .write_data   (write_data),
        .xfer_size    (xfer_size),
        .read_data    (read_data)
    );

    always #5 clk = ~clk;

    function automatic bit m_legal(input logic [63:0] a, input logic [3:0] n);
        logic [64:0] last;
        if (!(n == 1 || n == 2 || n == 4 || n == 8)) return 1'b0;
        if ((a % 64'(n)) != 0) return 1'b0;
        last = {1'b0, a} + 65'(n);
        return last <= 65'(MB);
    endfunction

    function automatic logic [63:0] m_read(input bit re, input logic [63:0] a, input logic [3:0] n);
        logic [63:0] v = '0;
        if (!re || !m_legal(a, n)) return '0;
        for (int i = 0; i < int'(n); i++) v = (v << 8) | 64'(model_mem[int'(a[9:0]) + i]);
        return v;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < MB; i++) model_mem[i] = 8'h00;
    endtask

    always @(posedge reset) m_clear();

    always @(posedge clk) begin
        if (reset) begin
            m_clear();
        end else if (write_enable && m_legal(address, xfer_size)) begin
            for (int i = 0; i < int'(xfer_size); i++)
                model_mem[int'(address[9:0]) + i] = 8'(write_data >> (8 * (int'(xfer_size) - 1 - i)));
        end
    end

    always @(negedge clk) begin
        if (compare_on) begin
            logic [63:0] exp;
            exp = m_read(read_enable, address, xfer_size);
            checks++;
            if (read_data !== exp) begin
                errors++;
                $display("FAIL model_cmp t=%0t addr=%h size=%0d got=%h exp=%h",
                         $time, address, xfer_size, read_data, exp);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] exp);
        checks++;
        if (read_data !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, read_data, exp);
        end
    endtask

    task automatic drive(input bit we, input bit re, input logic [63:0] a,
                         input logic [63:0] d, input logic [3:0] n);
        @(posedge clk);
        #2;
        write_enable = we;
        read_enable  = re;
        address      = a;
        write_data   = d;
        xfer_size    = n;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        m_clear();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        compare_on = 1'b1;

        for (int a = 0; a <= 1016; a += 8) begin
            drive(0, 1, 64'(a), '0, 4'd8);
            check("reset_zero", 64'h0);
        end

        drive(1, 1, 64'd16, 64'h0123456789ABCDEF, 4'd8);
        check("pre_write_old", 64'h0);
        drive(0, 1, 64'd16, '0, 4'd8);
        check("rd8_16", 64'h0123456789ABCDEF);
        drive(0, 1, 64'd16, '0, 4'd1);
        check("rd1_16", 64'h01);
        drive(0, 1, 64'd23, '0, 4'd1);
        check("rd1_23", 64'hEF);
        drive(0, 1, 64'd18, '0, 4'd2);
        check("rd2_18", 64'h4567);
        drive(0, 1, 64'd20, '0, 4'd4);
        check("rd4_20", 64'h89ABCDEF);
        drive(0, 0, 64'd16, '0, 4'd8);
        check("re_low", 64'h0);

        drive(1, 0, 64'd17, 64'hFFFF_FFFF_FFFF_00AA, 4'd1);
        drive(0, 1, 64'd16, '0, 4'd8);
        check("byte_store", 64'h01AA456789ABCDEF);

        drive(1, 1, 64'd3, 64'hDEAD, 4'd2);
        check("misaligned_rd", 64'h0);
        drive(1, 1, 64'd1020, 64'hA5A5_A5A5_A5A5_A5A5, 4'd8);
        check("oor_rd", 64'h0);
        drive(0, 1, 64'd0, '0, 4'd8);
        check("after_misaligned", 64'h0);
        drive(0, 1, 64'd1016, '0, 4'd8);
        check("after_oor", 64'h0);
        drive(0, 1, 64'd1020, '0, 4'd4);
        check("top_word_legal", 64'h0);
        drive(0, 1, 64'h1_0000_0010, '0, 4'd8);
        check("upper_addr_bits", 64'h0);
        drive(0, 1, 64'd16, '0, 4'd3);
        check("bad_size", 64'h0);
        drive(0, 1, 64'd16, '0, 4'd8);
        check("illegal_no_change", 64'h01AA456789ABCDEF);

        drive(1, 0, 64'd1020, 64'h0BAD_F00D, 4'd4);
        drive(0, 1, 64'd1022, '0, 4'd2);
        check("top_half", 64'hF00D);

        drive(1, 0, 64'd40, 64'hCAFEBABE, 4'd4);
        drive(1, 1, 64'd40, 64'h11223344, 4'd4);
        check("rw_old", 64'hCAFEBABE);
        @(posedge clk);
        #1;
        check("rw_new", 64'h11223344);

        drive(0, 1, 64'd16, '0, 4'd8);
        check("pre_reset", 64'h01AA456789ABCDEF);
        #1 reset = 1'b1;
        #1 check("async_clear", 64'h0);
        drive(1, 1, 64'd16, 64'h55, 4'd1);
        check("write_in_reset_rd", 64'h0);
        @(posedge clk);
        #2 reset = 1'b0;
        write_data   = 64'h77;
        address      = 64'd8;
        read_enable  = 1'b1;
        drive(0, 1, 64'd16, '0, 4'd8);
        check("reset_write_discarded", 64'h0);
        drive(0, 1, 64'd8, '0, 4'd1);
        check("post_release_write", 64'h77);
        drive(0, 1, 64'd40, '0, 4'd4);
        check("cleared_40", 64'h0);

        @(posedge clk);
        compare_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
